rggen_register_access_controller: RTL and testbench
===================================================

Name: rggen_register_access_controller

Overview:
- Host-side command stage directly upstream of the per-register address decoders.
- Accepts one bus command at a time over a valid/ready handshake and drives the shared read/write/address/write-data strobes into the decoders.
- Collects the per-register select and read-data vectors and returns a single registered response with read data and error status.

Parameters:
- ADDRESS_WIDTH, 16: width of command and register-side address.
- DATA_WIDTH, 32: data width. Multiple of 8, at least 8.
- TOTAL_REGISTERS, 4: number of register select/read-data slices. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_command_valid  input  1  host command present.
- o_command_ready  output  1  controller can accept a command.
- i_command_write  input  1  1 = write, 0 = read.
- i_command_address  input  ADDRESS_WIDTH  byte address.
- i_command_write_data  input  DATA_WIDTH  write data.
- i_command_strobe  input  DATA_WIDTH/8  byte enables for writes.
- o_response_valid  output  1  response present.
- i_response_ready  input  1  host accepts response.
- o_response_error  output  1  1 = no register selected.
- o_response_read_data  output  DATA_WIDTH  read data; 0 for writes and errors.
- o_read  output  1  read strobe to decoders.
- o_write  output  1  write strobe to decoders.
- o_address  output  ADDRESS_WIDTH  aligned address to decoders.
- o_write_data  output  DATA_WIDTH  write data to registers.
- o_write_strobe  output  DATA_WIDTH/8  byte enables to registers.
- i_select  input  TOTAL_REGISTERS  per-register select from decoders.
- i_read_data  input  TOTAL_REGISTERS*DATA_WIDTH  per-register read data; slice k is bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (rst=1 at edge) forces:
  - state IDLE;
  - all outputs 0, except o_command_ready=1 in the cycle after reset releases;
  - any in-flight command or pending response is discarded, with no strobe or response emitted.
- States: IDLE, ACCESS, RESPONSE.
- IDLE:
  - o_command_ready=1.
  - On i_command_valid && o_command_ready, register write flag, address, data and strobe, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - o_read = !write_flag and o_write = write_flag.
  - i_select and i_read_data are sampled combinationally in this cycle.
  - Next state is RESPONSE.
- RESPONSE:
  - o_response_valid=1; outputs are held stable until i_response_ready=1.
  - On the handshake go to IDLE. o_command_ready is 0 in that same cycle; no back-to-back acceptance.
- Latency: command accepted at edge N, strobe during cycle N+1, response valid from cycle N+2.
- Minimum cycle per command: 3 clocks.
- o_command_ready is 0 in ACCESS and RESPONSE.
- o_read and o_write are never both 1, and are 0 outside ACCESS.
- o_address, o_write_data and o_write_strobe hold the captured values from acceptance until the next acceptance; they are not cleared on return to IDLE.
- Alignment: o_address = captured address with its low log2(DATA_WIDTH/8) bits forced to 0.
- Read strobe: o_write_strobe is forced to all-ones on reads.
- Response error: o_response_error = (i_select == 0) sampled in ACCESS.
- Response read data (reads only): bitwise OR over k of (i_read_data slice k AND replicate(i_select[k])).
  - Multiple selects OR together with error=0 (decoder-map overlap is a configuration error, not flagged).
  - Writes and errors return data 0.
- Host inputs are ignored while o_command_ready=0.
- i_response_ready is ignored outside RESPONSE.

Test Plan:
- Reset then read of 0x0004, i_select=4'b0010, slice1=0xDEADBEEF:
  - o_read=1 for exactly one cycle with o_address=0x0004;
  - o_response_valid two cycles after accept with data 0xDEADBEEF and error 0.
- Write to 0x0009, data 0x12345678, strobe 4'b0011, i_select=4'b0001:
  - o_write pulse with o_address=0x0008, o_write_data=0x12345678, o_write_strobe=4'b0011;
  - response error 0, data 0.
- Read with i_select=0:
  - response error=1, data=0x00000000.
  - Write with i_select=0 gives error=1.
- Back-pressure: hold i_response_ready=0 for 5 cycles.
  - Response stays valid and stable, o_command_ready stays 0, and a second asserted command is not accepted.
  - Accept occurs only after the response handshake plus one cycle.
- Overlap read: i_select=4'b0101, slice0=0x00F0, slice2=0x0F00.
  - Data=0x00000FF0, error 0.
- Reset asserted during ACCESS and, separately, during RESPONSE:
  - Next cycle all outputs 0 and no response emitted.
  - o_command_ready=1 after reset deasserts.

Source files
------------

// File: rtl/rggen_register_access_controller.sv
// Host command stage ahead of the register address decoders: accepts one command,
// strobes the decoders for one cycle, and returns a registered response.
module rggen_register_access_controller #(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_command_valid,
    output logic                                  o_command_ready,
    input  logic                                  i_command_write,
    input  logic [ADDRESS_WIDTH-1:0]              i_command_address,
    input  logic [DATA_WIDTH-1:0]                 i_command_write_data,
    input  logic [DATA_WIDTH/8-1:0]               i_command_strobe,
    output logic                                  o_response_valid,
    input  logic                                  i_response_ready,
    output logic                                  o_response_error,
    output logic [DATA_WIDTH-1:0]                 o_response_read_data,
    output logic                                  o_read,
    output logic                                  o_write,
    output logic [ADDRESS_WIDTH-1:0]              o_address,
    output logic [DATA_WIDTH-1:0]                 o_write_data,
    output logic [DATA_WIDTH/8-1:0]               o_write_strobe,
    input  logic [TOTAL_REGISTERS-1:0]            i_select,
    input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_read_data
);
    localparam int BYTE_LSB = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 0;
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {ADDRESS_WIDTH{1'b1}} << BYTE_LSB;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } state_e;

    state_e                     state;
    state_e                     state_next;
    logic                       accept;
    logic                       write_flag;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]      write_data;
    logic [DATA_WIDTH/8-1:0]    write_strobe;
    logic                       resp_error;
    logic [DATA_WIDTH-1:0]      resp_data;
    logic [DATA_WIDTH-1:0]      merged_data;

    // Overlapping selects simply OR together; the decoder map owns uniqueness.
    always_comb begin
        merged_data = '0;
        for (int k = 0; k < TOTAL_REGISTERS; k++) begin
            if (i_select[k]) begin
                merged_data = merged_data | i_read_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_next      = state;
        o_command_ready = 1'b0;
        o_read          = 1'b0;
        o_write         = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0 during reset.
                o_command_ready = !rst;
                if (i_command_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                o_read     = !write_flag;
                o_write    = write_flag;
                state_next = RESPONSE;
            end
            RESPONSE: begin
                if (i_response_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && i_command_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            write_flag   <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            write_strobe <= '0;
            resp_error   <= 1'b0;
            resp_data    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_flag   <= i_command_write;
                address      <= i_command_address & ALIGN_MASK;
                write_data   <= i_command_write_data;
                write_strobe <= i_command_write ? i_command_strobe : '1;
            end
            if (state == ACCESS) begin
                resp_error <= (i_select == '0);
                resp_data  <= write_flag ? '0 : merged_data;
            end
        end
    end

    assign o_response_valid     = (state == RESPONSE);
    assign o_response_error     = (state == RESPONSE) && resp_error;
    assign o_response_read_data = (state == RESPONSE) ? resp_data : '0;
    assign o_address            = address;
    assign o_write_data         = write_data;
    assign o_write_strobe       = write_strobe;
endmodule

// File: tb/tb_rggen_register_access_controller.sv
// Bench for rggen_register_access_controller: directed vector table, hand-written
// back-pressure/reset sequences, and random commands against a reference model.
module tb_rggen_register_access_controller;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int SW = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [AW-1:0]        cmd_address;
    logic [DW-1:0]        cmd_wdata;
    logic [SW-1:0]        cmd_strobe;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_error;
    logic [DW-1:0]        resp_data;
    logic                 rd_strobe;
    logic                 wr_strobe;
    logic [AW-1:0]        reg_address;
    logic [DW-1:0]        reg_wdata;
    logic [SW-1:0]        reg_strobe;
    logic [NR-1:0]        select;
    logic [NR-1:0][DW-1:0] read_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rggen_register_access_controller #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR)
    ) dut (
        .clk(clk), .rst(rst),
        .i_command_valid(cmd_valid), .o_command_ready(cmd_ready),
        .i_command_write(cmd_write), .i_command_address(cmd_address),
        .i_command_write_data(cmd_wdata), .i_command_strobe(cmd_strobe),
        .o_response_valid(resp_valid), .i_response_ready(resp_ready),
        .o_response_error(resp_error), .o_response_read_data(resp_data),
        .o_read(rd_strobe), .o_write(wr_strobe), .o_address(reg_address),
        .o_write_data(reg_wdata), .o_write_strobe(reg_strobe),
        .i_select(select), .i_read_data(read_data)
    );

    typedef struct {
        string             name;
        logic              write;
        logic [AW-1:0]     addr;
        logic [DW-1:0]     wdata;
        logic [SW-1:0]     strb;
        logic [NR-1:0]     sel;
        logic [NR-1:0][DW-1:0] rd;
        logic              exp_err;
        logic [DW-1:0]     exp_data;
        int                hold;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: error when nothing selects; read data is the OR of selected slices.
    function automatic void model(input logic wr, input logic [NR-1:0] sel,
                                  input logic [NR-1:0][DW-1:0] rd,
                                  output logic err, output logic [DW-1:0] d);
        err = (sel == '0);
        d   = '0;
        if (!wr) for (int k = 0; k < NR; k++) if (sel[k]) d = d | rd[k];
    endfunction

    task automatic check_quiet(input string nm, input logic exp_ready);
        check({nm, ":ready"}, cmd_ready, exp_ready);
        check({nm, ":rvalid"}, resp_valid, 0);
        check({nm, ":rerr"}, resp_error, 0);
        check({nm, ":rdata"}, resp_data, 0);
        check({nm, ":rd"}, rd_strobe, 0);
        check({nm, ":wr"}, wr_strobe, 0);
    endtask

    task automatic run_cmd(input vec_t v);
        logic [AW-1:0] exp_addr;
        logic [SW-1:0] exp_strb;
        int n;
        exp_addr = v.addr - (v.addr % AW'(SW));
        exp_strb = v.write ? v.strb : {SW{1'b1}};
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
        check({v.name, ":ready"}, cmd_ready, 1);
        cmd_valid = 1; cmd_write = v.write; cmd_address = v.addr;
        cmd_wdata = v.wdata; cmd_strobe = v.strb;
        select = v.sel; read_data = v.rd;
        @(negedge clk);
        cmd_valid = 0; cmd_write = ~v.write; cmd_address = ~v.addr;
        cmd_wdata = ~v.wdata; cmd_strobe = ~v.strb;
        check({v.name, ":acc_rd"}, rd_strobe, !v.write);
        check({v.name, ":acc_wr"}, wr_strobe, v.write);
        check({v.name, ":acc_addr"}, reg_address, exp_addr);
        check({v.name, ":acc_wdata"}, reg_wdata, v.wdata);
        check({v.name, ":acc_strb"}, reg_strobe, exp_strb);
        check({v.name, ":acc_ready"}, cmd_ready, 0);
        check({v.name, ":acc_rvalid"}, resp_valid, 0);
        @(negedge clk);
        select = ~v.sel; read_data = {$urandom, $urandom, $urandom, $urandom};
        for (int h = 0; h <= v.hold; h++) begin
            check({v.name, ":rsp_valid"}, resp_valid, 1);
            check({v.name, ":rsp_err"}, resp_error, v.exp_err);
            check({v.name, ":rsp_data"}, resp_data, v.exp_data);
            check({v.name, ":rsp_strobes"}, {rd_strobe, wr_strobe}, 0);
            check({v.name, ":rsp_ready"}, cmd_ready, 0);
            check({v.name, ":rsp_addr"}, reg_address, exp_addr);
            if (h < v.hold) @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        check_quiet({v.name, ":post"}, 1);
        check({v.name, ":post_addr"}, reg_address, exp_addr);
    endtask

    task automatic start_cmd(input logic wr, input logic [AW-1:0] addr);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_address = addr;
        cmd_wdata = 32'hCAFE_F00D; cmd_strobe = 4'hF;
        select = 4'b0001; read_data = '0; read_data[0] = 32'h1111_2222;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    initial begin
        vec_t v;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_wdata = '0;
        cmd_strobe = '0; resp_ready = 0; select = '0; read_data = '0;

        v = '{name:"read4", write:0, addr:16'h0004, wdata:0, strb:0, sel:4'b0010,
              rd:'{0, 0, 32'hDEADBEEF, 0}, exp_err:0, exp_data:32'hDEADBEEF, hold:0};
        vecs.push_back(v);
        v = '{name:"write9", write:1, addr:16'h0009, wdata:32'h12345678, strb:4'b0011,
              sel:4'b0001, rd:'{0, 0, 0, 32'h5555AAAA}, exp_err:0, exp_data:0, hold:1};
        vecs.push_back(v);
        v = '{name:"read_nosel", write:0, addr:16'h0100, wdata:0, strb:0, sel:4'b0000,
              rd:'{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
              exp_err:1, exp_data:0, hold:0};
        vecs.push_back(v);
        v = '{name:"write_nosel", write:1, addr:16'h0102, wdata:32'hA5A5A5A5, strb:4'b1000,
              sel:4'b0000, rd:'{0, 0, 0, 0}, exp_err:1, exp_data:0, hold:0};
        vecs.push_back(v);
        v = '{name:"overlap", write:0, addr:16'h000F, wdata:0, strb:4'b0101, sel:4'b0101,
              rd:'{32'h77770000, 32'h00000F00, 32'h12340000, 32'h000000F0},
              exp_err:0, exp_data:32'h00000FF0, hold:2};
        vecs.push_back(v);

        @(negedge clk);
        @(negedge clk);
        check_quiet("reset", 0);
        check("reset:addr", reg_address, 0);
        check("reset:wdata", reg_wdata, 0);
        check("reset:strb", reg_strobe, 0);
        rst = 0;
        @(negedge clk);
        check("reset_release:ready", cmd_ready, 1);

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Back-pressure: response must hold and a pending command must wait.
        start_cmd(0, 16'h0010);
        cmd_valid = 1; cmd_write = 1; cmd_address = 16'h0020;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("bp:rvalid", resp_valid, 1);
            check("bp:rdata", resp_data, 32'h1111_2222);
            check("bp:ready", cmd_ready, 0);
            check("bp:strobes", {rd_strobe, wr_strobe}, 0);
            check("bp:addr", reg_address, 16'h0010);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        check("bp:after_hs_ready", cmd_ready, 1);
        check("bp:after_hs_rvalid", resp_valid, 0);
        @(negedge clk);
        cmd_valid = 0;
        check("bp:second_wr", wr_strobe, 1);
        check("bp:second_addr", reg_address, 16'h0020);
        @(negedge clk);
        check("bp:second_rsp", resp_valid, 1);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;

        // Reset while in ACCESS, then while in RESPONSE.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            cmd_valid = 1; cmd_write = 0; cmd_address = 16'h0044;
            select = 4'b1000; read_data = '0; read_data[3] = 32'h9999_8888;
            @(negedge clk);
            cmd_valid = 0;
            if (r == 1) @(negedge clk);
            check("rst_mid:in_flight", rd_strobe | resp_valid, 1);
            rst = 1;
            @(negedge clk);
            check_quiet("rst_mid", 0);
            check("rst_mid:addr", reg_address, 0);
            rst = 0;
            @(negedge clk);
            check_quiet("rst_mid_release", 1);
        end

        for (int i = 0; i < 40; i++) begin
            v.name  = "rand";
            v.write = 1'($urandom);
            v.addr  = AW'($urandom);
            v.wdata = $urandom;
            v.strb  = SW'($urandom);
            v.sel   = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
            for (int k = 0; k < NR; k++) v.rd[k] = $urandom;
            v.hold  = $urandom_range(0, 2);
            model(v.write, v.sel, v.rd, v.exp_err, v.exp_data);
            run_cmd(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
